vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Scan-side partner of the graphics pixel generator.
- Generates 640x480@60 VGA timing from the system clock.
- Presents the current pixel coordinate (o_x_read/o_y_read) to the graphics block.
- Samples the RGB that graphics returns, blanks it outside the active area, and drives the VGA pins (RGB, HS, VS) with sync aligned to the pixel data.
- Emits a once-per-frame tick for the game state machine.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 3.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_POL, 0, sync asserted level (0 = active-low).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_r  in  4  red from graphics for the addressed pixel
- i_g  in  4  green from graphics for the addressed pixel
- i_b  in  4  blue from graphics for the addressed pixel
- o_x_read  out  10  pixel column currently addressed, 0..H_TOTAL-1
- o_y_read  out  10  pixel row currently addressed, 0..V_TOTAL-1
- o_r  out  4  VGA red pin
- o_g  out  4  VGA green pin
- o_b  out  4  VGA blue pin
- o_hs  out  1  VGA horizontal sync
- o_vs  out  1  VGA vertical sync
- o_active  out  1  high while o_r/o_g/o_b carry a visible pixel
- o_frame_tick  out  1  one-clk pulse at entry to vertical blanking

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Divider div counts 0..CLK_DIV-1 and wraps. pix_tick = (div == CLK_DIV-1).
- Counters h, v (10 bit) change only on pix_tick:
  - h wraps H_TOTAL-1 -> 0.
  - v increments on h wrap and wraps V_TOTAL-1 -> 0.
- o_x_read/o_y_read are registered copies of the next (h, v), updated on the pix_tick edge. They are held stable for a full pixel period (CLK_DIV clocks) and are not clamped during blanking.
- Graphics latency is 2 clocks (RAM read + output register). Therefore i_r/g/b for pixel (h, v) is valid from 2 clocks after the address change until the next address change. The capture edge is the next pix_tick, CLK_DIV clocks later, so CLK_DIV >= 3 is required.
- On each pix_tick, for the pixel (h, v) that was addressed during the ending period, all of the following register simultaneously:
  - act = (h < H_ACTIVE) && (v < V_ACTIVE).
  - {o_r,o_g,o_b} <= act ? {i_r,i_g,i_b} : 12'h000.
  - o_active <= act.
  - o_hs <= SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
  - o_vs <= SYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
  - Result: RGB, HS, VS and o_active always change on the same edge; pin output lags the address by exactly one pixel period.
- o_frame_tick is high for exactly one clock: the pix_tick on which h wraps and v goes V_ACTIVE-1 -> V_ACTIVE. Period is H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clocks.
- Reset (synchronous, any time, including mid-line or mid-sync):
  - div, h, v = 0; o_x_read = o_y_read = 0.
  - o_r/o_g/o_b = 0; o_active = 0; o_frame_tick = 0.
  - o_hs = o_vs = ~SYNC_POL.
  - The first pix_tick occurs CLK_DIV clocks after reset release and outputs pixel (0,0).
- Between pix_ticks, all outputs hold. i_r/g/b are ignored on non-tick clocks.
- Width rules: all comparisons are on 10-bit unsigned values; the parameters guarantee H_TOTAL, V_TOTAL <= 1024.

Decomposition:
- Package vga_timing_pkg holds:
  - the timing constants above;
  - derived H_TOTAL, V_TOTAL, HS_START/HS_END, VS_START/VS_END;
  - the 12-bit rgb444 typedef.
- One sub-module, vga_pix_div: the divider producing pix_tick (parameter CLK_DIV, ports clk/rst/o_tick).
- Counters, sync decode and the output register stay in vga_scan_ctrl.

Test Plan:
- Reset release:
  - Hold rst 5 clocks, then release.
  - o_hs = o_vs = 1, RGB = 0, o_active = 0 until clock 4.
  - At clock 4: o_active = 1 and o_x_read = 1, o_y_read = 0.
- Line timing:
  - Count pix_ticks from reset; o_hs falls on the tick outputting h = 656 and rises on h = 752.
  - Line period is 3200 clocks; o_active is high for 640 ticks per line.
- Frame timing:
  - o_vs is low for exactly 2 lines (v = 490, 491).
  - Consecutive o_frame_tick pulses are 1,680,000 clocks apart, each one clock wide.
- Data alignment:
  - Model graphics as a 2-clock pipeline returning i_r = x[3:0], i_g = y[3:0], i_b = 4'h5.
  - Pixel (37,12) appears on the pins as 5/C/5 (i_r = 37 mod 16 = 5, i_g = 12 mod 16 = C, i_b = 5).
  - That pixel is output one pixel period after o_x_read = 37, o_y_read = 12 is presented.
- Blanking:
  - Drive i_rgb = 12'hABC constantly.
  - Pins show 0 for h >= 640 or v >= 480, and 12'hABC elsewhere.
- Mid-frame reset:
  - Assert rst during HS pulse on line 300 for one clock.
  - Next clock: o_hs = 1, RGB = 0, counters = 0.
  - Timing restarts identically to the first reset.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Timing constants and pixel type shared by the VGA scan path.
package vga_timing_pkg;

    // 640x480@60 from a 100 MHz system clock
    localparam int   VGA_CLK_DIV  = 4;
    localparam int   VGA_H_ACTIVE = 640;
    localparam int   VGA_H_FP     = 16;
    localparam int   VGA_H_SYNC   = 96;
    localparam int   VGA_H_BP     = 48;
    localparam int   VGA_V_ACTIVE = 480;
    localparam int   VGA_V_FP     = 10;
    localparam int   VGA_V_SYNC   = 2;
    localparam int   VGA_V_BP     = 33;
    localparam logic VGA_SYNC_POL = 1'b0;

    // Derived line/frame geometry
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    // 4 bits each of red, green, blue packed as {r, g, b}
    typedef logic [11:0] rgb444_t;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: one-clock tick every CLK_DIV system clocks.
module vga_pix_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = VGA_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // Free-running modulo-CLK_DIV counter, restarted by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign o_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: pixel/line counters, address to graphics, sync
// decode and a single output register so RGB, HS, VS and active all
// change on the same edge, one pixel period after the address.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = VGA_CLK_DIV,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_r,
    input  logic [3:0] i_g,
    input  logic [3:0] i_b,
    output logic [9:0] o_x_read,
    output logic [9:0] o_y_read,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_active,
    output logic       o_frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] V_VIS_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic    pix_tick;
    logic [9:0] h;
    logic [9:0] v;
    logic    act;
    logic    in_hs;
    logic    in_vs;
    rgb444_t pix_in;
    rgb444_t rgb;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .o_tick (pix_tick)
    );

    // Decode of the pixel addressed during the current period
    always_comb begin
        act    = (h < H_VIS) && (v < V_VIS);
        in_hs  = (h >= HS_START) && (h < HS_END);
        in_vs  = (v >= VS_START) && (v < VS_END);
        pix_in = {i_r, i_g, i_b};
    end

    // Scan counters plus pin register; everything advances on pix_tick only
    always_ff @(posedge clk) begin
        if (rst) begin
            h            <= '0;
            v            <= '0;
            rgb          <= '0;
            o_active     <= 1'b0;
            o_hs         <= ~SYNC_POL;
            o_vs         <= ~SYNC_POL;
            o_frame_tick <= 1'b0;
        end else begin
            // Frame tick marks the last visible pixel leaving: entry to vblank
            o_frame_tick <= pix_tick && (h == H_LAST) && (v == V_VIS_LAST);
            if (pix_tick) begin
                rgb      <= act ? pix_in : '0;
                o_active <= act;
                o_hs     <= in_hs ? SYNC_POL : ~SYNC_POL;
                o_vs     <= in_vs ? SYNC_POL : ~SYNC_POL;
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    // The counters are themselves the registered read address
    assign o_x_read = h;
    assign o_y_read = v;
    assign o_r      = rgb[11:8];
    assign o_g      = rgb[7:4];
    assign o_b      = rgb[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: one instance at full 640x480 timing, one at a
// shrunken geometry so whole frames fit in a short run.
module tb_vga_scan_ctrl;

    localparam int CD = 4;

    typedef struct {
        int ha, hfp, hsy, hbp, va, vfp, vsy, vbp;
    } tim_t;

    typedef struct {
        logic [9:0]  x, y;
        logic [11:0] rgb;
        logic        hs, vs, act, ft;
    } exp_t;

    typedef struct {
        int          sel;   // 0 = full-size instance, 1 = small instance
        int          n;     // clocks since reset release
        logic [9:0]  x, y;
        logic [11:0] rgb;
        logic        hs, vs, act;
    } vec_t;

    typedef enum int {M_PAT, M_RAND, M_CONST} mode_t;

    localparam tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam tim_t TB = '{40, 4, 6, 5, 20, 2, 2, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mode_t       mode = M_PAT;
    logic [11:0] drv_rgb = '0;

    logic [9:0]  a_x, a_y, b_x, b_y;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_act, a_ft, b_hs, b_vs, b_act, b_ft;
    logic [11:0] ga1, ga2, gb1, gb2, rgb_a, rgb_b;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic [11:0] cap_a = '0, cap_b = '0;

    // Graphics stand-in: 2-clock pipeline returning {x[3:0], y[3:0], 5}
    always @(posedge clk) begin
        ga1 <= {a_x[3:0], a_y[3:0], 4'h5};
        ga2 <= ga1;
        gb1 <= {b_x[3:0], b_y[3:0], 4'h5};
        gb2 <= gb1;
    end
    assign rgb_a = (mode == M_PAT) ? ga2 : drv_rgb;
    assign rgb_b = (mode == M_PAT) ? gb2 : drv_rgb;

    vga_scan_ctrl dut_a (
        .clk(clk), .rst(rst),
        .i_r(rgb_a[11:8]), .i_g(rgb_a[7:4]), .i_b(rgb_a[3:0]),
        .o_x_read(a_x), .o_y_read(a_y),
        .o_r(a_r), .o_g(a_g), .o_b(a_b),
        .o_hs(a_hs), .o_vs(a_vs), .o_active(a_act), .o_frame_tick(a_ft)
    );

    vga_scan_ctrl #(
        .CLK_DIV(CD), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_r(rgb_b[11:8]), .i_g(rgb_b[7:4]), .i_b(rgb_b[3:0]),
        .o_x_read(b_x), .o_y_read(b_y),
        .o_r(b_r), .o_g(b_g), .o_b(b_b),
        .o_hs(b_hs), .o_vs(b_vs), .o_active(b_act), .o_frame_tick(b_ft)
    );

    // Reference: after n clocks, t = n/CD pixel periods have completed;
    // pins show pixel t-1 in raster order, the address is pixel t.
    function automatic exp_t model(input tim_t T, input int nn, input logic [11:0] cap);
        exp_t e;
        int ht, vt, t, p, h, v, hs0, vs0;
        ht  = T.ha + T.hfp + T.hsy + T.hbp;
        vt  = T.va + T.vfp + T.vsy + T.vbp;
        hs0 = T.ha + T.hfp;
        vs0 = T.va + T.vfp;
        t   = nn / CD;
        e.x   = 10'(t % ht);
        e.y   = 10'((t / ht) % vt);
        e.rgb = '0;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.act = 1'b0;
        e.ft  = 1'b0;
        if (t > 0) begin
            p = t - 1;
            h = p % ht;
            v = (p / ht) % vt;
            e.act = (h < T.ha) && (v < T.va);
            e.rgb = e.act ? cap : 12'h000;
            e.hs  = !((h >= hs0) && (h < hs0 + T.hsy));
            e.vs  = !((v >= vs0) && (v < vs0 + T.vsy));
            e.ft  = (nn % CD == 0) && (h == ht - 1) && (v == T.va - 1);
        end
        return e;
    endfunction

    // Expected graphics colour for the pixel captured on the edge reaching nn
    function automatic logic [11:0] pat(input tim_t T, input int nn);
        int ht, vt, p;
        logic [9:0] hh, vv;
        ht = T.ha + T.hfp + T.hsy + T.hbp;
        vt = T.va + T.vfp + T.vsy + T.vbp;
        p  = nn / CD - 1;
        hh = 10'(p % ht);
        vv = 10'((p / ht) % vt);
        return {hh[3:0], vv[3:0], 4'h5};
    endfunction

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s n=%0d actual=%0h required=%0h", name, n, actual, expected);
        end
    endtask

    task automatic check_dut(input string tag, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                             input logic [11:0] rgb, input logic hs, input logic vs,
                             input logic act, input logic ft);
        chk({tag, "_x"},   {22'b0, x},   {22'b0, e.x});
        chk({tag, "_y"},   {22'b0, y},   {22'b0, e.y});
        chk({tag, "_rgb"}, {20'b0, rgb}, {20'b0, e.rgb});
        chk({tag, "_hs"},  {31'b0, hs},  {31'b0, e.hs});
        chk({tag, "_vs"},  {31'b0, vs},  {31'b0, e.vs});
        chk({tag, "_act"}, {31'b0, act}, {31'b0, e.act});
        chk({tag, "_ft"},  {31'b0, ft},  {31'b0, e.ft});
    endtask

    // One clock: drive at negedge, update the model at posedge, compare at +1
    task automatic step(input logic r);
        logic [11:0] sa, sb;
        @(negedge clk);
        rst = r;
        if (mode == M_RAND)       drv_rgb = 12'($urandom);
        else if (mode == M_CONST) drv_rgb = 12'hABC;
        #1;
        sa = rgb_a;
        sb = rgb_b;
        @(posedge clk);
        if (r) begin
            n     = 0;
            cap_a = '0;
            cap_b = '0;
        end else begin
            n++;
            if (n % CD == 0) begin
                cap_a = (mode == M_PAT) ? pat(TA, n) : sa;
                cap_b = (mode == M_PAT) ? pat(TB, n) : sb;
            end
        end
        #1;
        check_dut("a", model(TA, n, cap_a), a_x, a_y, {a_r, a_g, a_b}, a_hs, a_vs, a_act, a_ft);
        check_dut("b", model(TB, n, cap_b), b_x, b_y, {b_r, b_g, b_b}, b_hs, b_vs, b_act, b_ft);
    endtask

    vec_t vecs[15];
    int   ft_cnt, act_cnt, vs_cnt;
    int   ft_n[2];

    initial begin
        // Hand-derived checkpoints, ordered by clocks since reset release
        vecs[0]  = '{0,    3, 10'd0,   10'd0,  12'h000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{0,    4, 10'd1,   10'd0,  12'h005, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{0,  152, 10'd38,  10'd0,  12'h505, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{0, 2560, 10'd640, 10'd0,  12'hF05, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{0, 2564, 10'd641, 10'd0,  12'h000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{0, 2624, 10'd656, 10'd0,  12'h000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{0, 2628, 10'd657, 10'd0,  12'h000, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1, 2788, 10'd37,  10'd12, 12'h4C5, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1, 2792, 10'd38,  10'd12, 12'h5C5, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{0, 3008, 10'd752, 10'd0,  12'h000, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{0, 3012, 10'd753, 10'd0,  12'h000, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{0, 3200, 10'd0,   10'd1,  12'h000, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{0, 3203, 10'd0,   10'd1,  12'h000, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{0, 3204, 10'd1,   10'd1,  12'h015, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{0, 3208, 10'd2,   10'd1,  12'h115, 1'b1, 1'b1, 1'b1};

        // Power-on reset for 5 clocks with the graphics pattern attached
        mode = M_PAT;
        for (int i = 0; i < 5; i++) step(1'b1);

        for (int k = 0; k < 15; k++) begin
            while (n < vecs[k].n) step(1'b0);
            if (vecs[k].sel == 0) begin
                chk($sformatf("tbl%0d_x", k),   {22'b0, a_x},           {22'b0, vecs[k].x});
                chk($sformatf("tbl%0d_y", k),   {22'b0, a_y},           {22'b0, vecs[k].y});
                chk($sformatf("tbl%0d_rgb", k), {20'b0, a_r, a_g, a_b}, {20'b0, vecs[k].rgb});
                chk($sformatf("tbl%0d_hs", k),  {31'b0, a_hs},          {31'b0, vecs[k].hs});
                chk($sformatf("tbl%0d_vs", k),  {31'b0, a_vs},          {31'b0, vecs[k].vs});
                chk($sformatf("tbl%0d_act", k), {31'b0, a_act},         {31'b0, vecs[k].act});
            end else begin
                chk($sformatf("tbl%0d_x", k),   {22'b0, b_x},           {22'b0, vecs[k].x});
                chk($sformatf("tbl%0d_y", k),   {22'b0, b_y},           {22'b0, vecs[k].y});
                chk($sformatf("tbl%0d_rgb", k), {20'b0, b_r, b_g, b_b}, {20'b0, vecs[k].rgb});
                chk($sformatf("tbl%0d_hs", k),  {31'b0, b_hs},          {31'b0, vecs[k].hs});
                chk($sformatf("tbl%0d_vs", k),  {31'b0, b_vs},          {31'b0, vecs[k].vs});
                chk($sformatf("tbl%0d_act", k), {31'b0, b_act},         {31'b0, vecs[k].act});
            end
        end

        // Mid-frame reset while the small instance is inside HS on line 15
        while (n < 3489) step(1'b0);
        chk("mid_in_hs", {31'b0, b_hs}, 32'd0);
        step(1'b1);
        chk("mid_hs",  {31'b0, b_hs},  32'd1);
        chk("mid_x",   {22'b0, b_x},   32'd0);
        chk("mid_y",   {22'b0, b_y},   32'd0);
        chk("mid_rgb", {20'b0, b_r, b_g, b_b}, 32'd0);
        chk("mid_ax",  {22'b0, a_x},   32'd0);

        // Random colours after restart; measure frame tick spacing
        mode    = M_RAND;
        ft_cnt  = 0;
        act_cnt = 0;
        vs_cnt  = 0;
        ft_n[0] = 0;
        ft_n[1] = 0;
        for (int i = 0; i < 12000 && ft_cnt < 2; i++) begin
            step(1'b0);
            if (b_ft) begin
                if (ft_cnt < 2) ft_n[ft_cnt] = n;
                ft_cnt++;
            end
            if (n % CD == 0 && n >= 4 && n <= 3200 && a_act) act_cnt++;
            if (n % CD == 0 && n >= 4 && n <= 5940 && !b_vs) vs_cnt++;
        end
        chk("ft_count",  ft_cnt,            32'd2);
        chk("ft_first",  ft_n[0],           32'd4400);
        chk("ft_period", ft_n[1] - ft_n[0], 32'd5940);
        chk("line_active_ticks", act_cnt,   32'd640);
        chk("vs_low_ticks", vs_cnt,         32'd110);

        // Constant colour: blanking must zero everything outside active
        mode = M_CONST;
        for (int i = 0; i < 5940; i++) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
